// File: rtl/hi_iso14443a.sv
// ISO 14443-A high-frequency front end: per-bit-window pause/subcarrier detection,
// SSP bit framing toward the host and antenna driver gating for tag/reader modulation.
module hi_iso14443a #(
  parameter logic [7:0] PAUSE_TH = 8'd40,
  parameter logic [7:0] SUBC_TH  = 8'd24
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       ck_1356megb,
  input  logic       pck0,
  input  logic       cross_hi,
  input  logic       cross_lo,
  input  logic [7:0] adc_d,
  input  logic [2:0] mod_type,
  input  logic       ssp_dout,
  output logic       adc_clk,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       pwr_hi,
  output logic       pwr_lo,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       dbg
);

  typedef enum logic [2:0] {
    ModeSniffer      = 3'b000,
    ModeTagListen    = 3'b001,
    ModeTagMod       = 3'b010,
    ModeReaderListen = 3'b011,
    ModeReaderMod    = 3'b100
  } mode_e;

  mode_e      mode;

  logic [6:0] cnt_q, cnt_d;
  logic       frame_q, frame_d;
  logic       din_q, din_d;
  logic       mod_bit_q, mod_bit_d;
  logic       oe_q, oe_d;
  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;
  logic       pause_q, pause_d;

  logic       win_end;
  logic [7:0] win_min;
  logic [7:0] win_max;
  logic [7:0] win_swing;
  logic       win_pause;
  logic       win_subc;
  logic       win_result;

  logic       unused_inputs;
  assign unused_inputs = ^{pck0, cross_hi, cross_lo};

  // Reserved encodings fall back to sniffing.
  always_comb begin
    mode = ModeSniffer;
    case (mod_type)
      3'b001:  mode = ModeTagListen;
      3'b010:  mode = ModeTagMod;
      3'b011:  mode = ModeReaderListen;
      3'b100:  mode = ModeReaderMod;
      default: mode = ModeSniffer;
    endcase
  end

  // Window statistics include the current sample so the last clock of a window counts.
  always_comb begin
    win_end   = (cnt_q[3:0] == 4'hf);
    win_min   = (adc_d < min_q) ? adc_d : min_q;
    win_max   = (adc_d > max_q) ? adc_d : max_q;
    win_pause = pause_q | (adc_d < PAUSE_TH);
    win_swing = win_max - win_min;
    win_subc  = (win_swing > SUBC_TH);
  end

  always_comb begin
    win_result = win_pause | win_subc;
    case (mode)
      ModeTagListen,
      ModeTagMod:       win_result = win_pause;
      ModeReaderListen,
      ModeReaderMod:    win_result = win_subc;
      default:          win_result = win_pause | win_subc;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + 7'd1;
    frame_d   = (cnt_q[6:4] == 3'd0);
    din_d     = din_q;
    mod_bit_d = mod_bit_q;
    oe_d      = (mode == ModeTagMod) & mod_bit_q & cnt_q[3];
    min_d     = win_min;
    max_d     = win_max;
    pause_d   = win_pause;

    if (cnt_q[3:0] == 4'h8) begin
      mod_bit_d = ssp_dout;
    end

    if (win_end) begin
      din_d   = win_result;
      min_d   = 8'hff;
      max_d   = 8'h00;
      pause_d = 1'b0;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      cnt_q     <= 7'd0;
      frame_q   <= 1'b0;
      din_q     <= 1'b0;
      mod_bit_q <= 1'b0;
      oe_q      <= 1'b0;
      min_q     <= 8'hff;
      max_q     <= 8'h00;
      pause_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      din_q     <= din_d;
      mod_bit_q <= mod_bit_d;
      oe_q      <= oe_d;
      min_q     <= min_d;
      max_q     <= max_d;
      pause_q   <= pause_d;
    end
  end

  // Carrier gating is combinational on the inverted clock; reset blanks the modulated case.
  always_comb begin
    pwr_hi = 1'b0;
    case (mode)
      ModeReaderListen: pwr_hi = ck_1356megb;
      ModeReaderMod:    pwr_hi = ck_1356megb & ~mod_bit_q & ~rst;
      default:          pwr_hi = 1'b0;
    endcase
  end

  assign adc_clk   = ck_1356meg;
  assign ssp_clk   = cnt_q[3];
  assign ssp_frame = frame_q;
  assign ssp_din   = din_q;
  assign dbg       = din_q;
  assign pwr_lo    = 1'b0;
  assign pwr_oe1   = oe_q;
  assign pwr_oe2   = 1'b0;
  assign pwr_oe3   = oe_q;
  assign pwr_oe4   = oe_q;

endmodule

// File: tb/tb_hi_iso14443a.sv
// Directed bench for hi_iso14443a: a cycle model tracks framing and drive gating,
// a queue holds the expected bit of every window until the DUT reports it.
module tb_hi_iso14443a;

  localparam logic [2:0] M_SNIF = 3'b000;
  localparam logic [2:0] M_TL   = 3'b001;
  localparam logic [2:0] M_TM   = 3'b010;
  localparam logic [2:0] M_RL   = 3'b011;
  localparam logic [2:0] M_RM   = 3'b100;
  localparam logic [2:0] M_RSV  = 3'b111;

  logic       ck;
  logic       ckb;
  logic       rst;
  logic       pck0;
  logic       cross_hi;
  logic       cross_lo;
  logic [7:0] adc_d;
  logic [2:0] mod_type;
  logic       ssp_dout;
  logic       adc_clk;
  logic       ssp_clk;
  logic       ssp_frame;
  logic       ssp_din;
  logic       pwr_hi;
  logic       pwr_lo;
  logic       pwr_oe1;
  logic       pwr_oe2;
  logic       pwr_oe3;
  logic       pwr_oe4;
  logic       dbg;

  int total;
  int bad;

  logic [6:0] m_cnt;
  logic       m_frame;
  logic       m_mod;
  logic       m_oe;
  logic       exp_q[$];

  hi_iso14443a dut (
    .ck_1356meg (ck),
    .rst        (rst),
    .ck_1356megb(ckb),
    .pck0       (pck0),
    .cross_hi   (cross_hi),
    .cross_lo   (cross_lo),
    .adc_d      (adc_d),
    .mod_type   (mod_type),
    .ssp_dout   (ssp_dout),
    .adc_clk    (adc_clk),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .pwr_hi     (pwr_hi),
    .pwr_lo     (pwr_lo),
    .pwr_oe1    (pwr_oe1),
    .pwr_oe2    (pwr_oe2),
    .pwr_oe3    (pwr_oe3),
    .pwr_oe4    (pwr_oe4),
    .dbg        (dbg)
  );

  assign ckb = ~ck;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, check carrier gating while ckb is high,
  // then check registered outputs just after the rising edge.
  task automatic step(input logic r, input logic [2:0] m, input logic [7:0] a, input logic d);
    logic n_frame, n_mod, n_oe, w_end, e_hi, e_bit;
    @(negedge ck);
    rst = r; mod_type = m; adc_d = a; ssp_dout = d;
    #1;
    if (m == M_RL)      e_hi = 1'b1;
    else if (r)         e_hi = 1'b0;
    else if (m == M_RM) e_hi = ~m_mod;
    else                e_hi = 1'b0;
    check("pwr_hi_ckb_high", pwr_hi, e_hi);
    if (r) begin
      n_frame = 1'b0; n_mod = 1'b0; n_oe = 1'b0; w_end = 1'b0;
    end else begin
      n_frame = (m_cnt[6:4] == 3'd0);
      n_mod   = (m_cnt[3:0] == 4'd8) ? d : m_mod;
      n_oe    = (m == M_TM) & m_mod & m_cnt[3];
      w_end   = (m_cnt[3:0] == 4'd15);
    end
    @(posedge ck);
    #1;
    m_cnt   = r ? 7'd0 : m_cnt + 7'd1;
    m_frame = n_frame;
    m_mod   = n_mod;
    m_oe    = n_oe;
    check("ssp_clk", ssp_clk, m_cnt[3]);
    check("ssp_frame", ssp_frame, m_frame);
    check("pwr_oe1", pwr_oe1, m_oe);
    check("pwr_oe3", pwr_oe3, m_oe);
    check("pwr_oe4", pwr_oe4, m_oe);
    check("pwr_oe2", pwr_oe2, 1'b0);
    check("pwr_lo", pwr_lo, 1'b0);
    check("pwr_hi_ckb_low", pwr_hi, 1'b0);
    check("adc_clk", adc_clk, ck);
    if (r) begin
      check("ssp_din_rst", ssp_din, 1'b0);
      check("dbg_rst", dbg, 1'b0);
    end
    if (w_end) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_empty observed=window_end expected=queued_bit");
      end else begin
        e_bit = exp_q.pop_front();
        check("ssp_din_window", ssp_din, e_bit);
        check("dbg_window", dbg, e_bit);
      end
    end
  endtask

  // Alternates a/b each clock; mode m1 for the first half, m2 for the second.
  task automatic window(input logic [2:0] m1, input logic [2:0] m2, input logic [7:0] a,
                        input logic [7:0] b, input logic d, input logic exp);
    exp_q.push_back(exp);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, (i < 8) ? m1 : m2, i[0] ? b : a, d);
    end
  endtask

  task automatic do_reset(input logic [2:0] m1, input logic [2:0] m2);
    exp_q.delete();
    step(1'b1, m1, 8'd0, 1'b0);
    step(1'b1, m2, 8'd0, 1'b0);
  endtask

  initial begin
    logic [7:0] byte_b5;
    total = 0; bad = 0;
    m_cnt = 7'd0; m_frame = 1'b0; m_mod = 1'b0; m_oe = 1'b0;
    rst = 1'b1; pck0 = 1'b0; cross_hi = 1'b0; cross_lo = 1'b0;
    adc_d = 8'd0; mod_type = M_RM; ssp_dout = 1'b0;

    // Reset: READER_MOD blanks pwr_hi, READER_LISTEN passes the carrier.
    do_reset(M_RM, M_RL);

    // Tag listen: pause vs no pause, then the threshold boundary.
    for (int i = 0; i < 3; i++) window(M_TL, M_TL, 8'd200, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) window(M_TL, M_TL, 8'd200, 8'd200, 1'b0, 1'b0);
    window(M_TL, M_TL, 8'd40, 8'd40, 1'b0, 1'b0);
    window(M_TL, M_TL, 8'd39, 8'd39, 1'b0, 1'b1);

    // Reader listen: swing 19, 24, 25 and full-scale; pauses alone are ignored.
    window(M_RL, M_RL, 8'd211, 8'd192, 1'b0, 1'b0);
    window(M_RL, M_RL, 8'd211, 8'd192, 1'b0, 1'b0);
    window(M_RL, M_RL, 8'd200, 8'd0, 1'b0, 1'b1);
    window(M_RL, M_RL, 8'd224, 8'd200, 1'b0, 1'b0);
    window(M_RL, M_RL, 8'd225, 8'd200, 1'b0, 1'b1);
    window(M_RL, M_RL, 8'd10, 8'd10, 1'b0, 1'b0);

    // Sniffer and reserved encodings: pause OR subcarrier.
    window(M_SNIF, M_SNIF, 8'd39, 8'd39, 1'b0, 1'b1);
    window(M_SNIF, M_SNIF, 8'd40, 8'd40, 1'b0, 1'b0);
    window(M_SNIF, M_SNIF, 8'd225, 8'd200, 1'b0, 1'b1);
    window(M_RSV, M_RSV, 8'd39, 8'd39, 1'b0, 1'b1);
    window(M_RSV, M_RSV, 8'd100, 8'd100, 1'b0, 1'b0);

    // Tag modulation: oe follows ssp_clk one clock late while bit=1.
    for (int i = 0; i < 4; i++) window(M_TM, M_TM, 8'd100, 8'd100, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) window(M_TM, M_TM, 8'd100, 8'd100, 1'b0, 1'b0);

    // Reader modulation: byte 0xB5 MSB first gates the carrier on '1' bits.
    byte_b5 = 8'hB5;
    for (int i = 7; i >= 0; i--) window(M_RM, M_RM, 8'd100, 8'd100, byte_b5[i], 1'b0);
    window(M_RM, M_RM, 8'd100, 8'd100, 1'b0, 1'b0);

    // Mid-window mode switches: the mode at window end selects the result.
    window(M_TL, M_TM, 8'd0, 8'd0, 1'b0, 1'b1);
    window(M_TL, M_TM, 8'd100, 8'd100, 1'b1, 1'b0);
    window(M_RL, M_TL, 8'd225, 8'd200, 1'b0, 1'b0);
    window(M_TL, M_RL, 8'd225, 8'd200, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) window(M_TL, M_TL, 8'd150, 8'd150, 1'b0, 1'b0);

    // Reset mid-window discards the pause seen before it.
    for (int i = 0; i < 5; i++) step(1'b0, M_TL, 8'd0, 1'b0);
    do_reset(M_TL, M_TL);
    window(M_TL, M_TL, 8'd200, 8'd200, 1'b0, 1'b0);
    window(M_TL, M_TL, 8'd0, 8'd200, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hi_iso14443a.md
HI_ISO14443A -- requirements
Module: hi_iso14443a

Interface
REQ-001 Parameter PAUSE_TH, default 8'd40: ADC level below which a sample counts as a reader pause.
REQ-002 Parameter SUBC_TH, default 8'd24: minimum window peak-to-peak ADC swing that counts as tag subcarrier.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 ck_1356meg  in  1  13.56 MHz system clock; all flops on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ck_1356megb  in  1  inverted carrier clock; used only combinationally for pwr_hi.
REQ-007 pck0, cross_hi, cross_lo  in  1 each  unused.
REQ-008 adc_d  in  8  unsigned ADC sample.
REQ-009 mod_type  in  3  mode select: 000 SNIFFER, 001 TAGSIM_LISTEN, 010 TAGSIM_MOD, 011 READER_LISTEN, 100 READER_MOD, 101-111 treated as SNIFFER.
REQ-010 ssp_dout  in  1  modulation bit from host.
REQ-011 adc_clk  out  1  equals ck_1356meg (pass-through).
REQ-012 ssp_clk, ssp_frame, ssp_din  out  1 each  serial clock, byte frame, received bit.
REQ-013 pwr_hi, pwr_lo, pwr_oe1..pwr_oe4  out  1 each  antenna drivers.
REQ-014 dbg  out  1  debug; equals ssp_din.

Function
REQ-015 7-bit free-running counter cnt SHALL increment every clock and wrap 127->0; mode changes SHALL NOT reset it.
REQ-016 ssp_clk SHALL equal cnt[3]: period 16 clocks, 50% duty (847.5 kHz); rising edge at cnt[3:0]=8, falling edge at wrap of cnt[3:0] to 0.
REQ-017 ssp_frame SHALL be a flop loaded each clock with (cnt[6:4]==0): high 16 clocks of every 128, lagging cnt by one clock.
REQ-018 Per bit window (cnt[3:0]=0..15), the block SHALL track min and max of adc_d and a pause flag (any sample < PAUSE_TH).
REQ-019 Subcarrier flag SHALL be (max - min) > SUBC_TH, unsigned 8-bit, no wrap (max >= min guaranteed).
REQ-020 At cnt[3:0]=15, the window result SHALL be computed including that clock's sample, and ssp_din SHALL be registered from it (valid from the ssp_clk falling edge); then min:=255, max:=0, pause:=0.
REQ-021 Result per mode: TAGSIM_LISTEN/TAGSIM_MOD = pause flag; READER_LISTEN/READER_MOD = subcarrier flag; SNIFFER and 101-111 = pause OR subcarrier.
REQ-022 mod_bit register SHALL capture ssp_dout at cnt[3:0]=8 (ssp_clk rising edge) and hold for 16 clocks.
REQ-023 TAGSIM_MOD: pwr_oe1, pwr_oe3 and pwr_oe4 SHALL be a flop loaded with mod_bit AND cnt[3]; pwr_oe2, pwr_hi and pwr_lo SHALL be 0.
REQ-024 READER_MOD: pwr_hi SHALL equal ck_1356megb AND NOT mod_bit (carrier pause while bit=1); pwr_lo and all pwr_oe SHALL be 0.
REQ-025 READER_LISTEN: pwr_hi SHALL equal ck_1356megb; pwr_lo and all pwr_oe SHALL be 0.
REQ-026 SNIFFER, TAGSIM_LISTEN and 101-111: pwr_hi, pwr_lo and pwr_oe1..4 SHALL be 0.
REQ-027 A mode change mid-window SHALL apply the new mode's result selection at the next window end; output gating SHALL change on the next clock.

Reset
REQ-028 While rst is high at a clock edge: cnt=0, ssp_frame=0, ssp_din=0, mod_bit=0, pwr_oe flop=0, min=255, max=0, pause=0.
REQ-029 During reset, ssp_clk=0, dbg=0 and all pwr_* outputs=0; pwr_hi is 0 in every mode except READER_LISTEN, where it follows ck_1356megb.
REQ-030 Reset asserted mid-byte SHALL abort the window; the first full window ends 16 clocks after release.

Verification
REQ-031 rst held 2 clocks, then released -> ssp_clk low 8 clocks then high 8; ssp_frame rises 1 clock after release and stays high 16 clocks, repeating every 128.
REQ-032 TAGSIM_LISTEN, adc_d alternating 200/0 each clock -> ssp_din=1 every bit; constant adc_d=200 -> ssp_din=0.
REQ-033 READER_LISTEN, adc_d alternating 211/192 (swing 19) -> ssp_din=0; alternating 200/0 -> ssp_din=1; pwr_hi tracks ck_1356megb.
REQ-034 TAGSIM_MOD, ssp_dout=1 -> pwr_oe1/3/4 toggle with ssp_clk, one clock late; ssp_dout=0 -> all 0.
REQ-035 READER_MOD, ssp_dout byte 0xB5 MSB first -> pwr_hi gated off during '1' bits, follows ck_1356megb during '0' bits.
REQ-036 Switching mod_type 001->010 mid-byte -> counter continues uninterrupted, frame spacing still 128 clocks.
